lsu_wb: RTL and testbench

- Load/store unit for the RV32I core. Sits between the execute stage and the data-memory bus.
- Accepts one memory op at a time and runs the bus handshake.
- Loads: aligns and extends the returned data, then drives the register-file write port (we/rd/rd_data) for exactly one cycle.
- Stores: complete with no register-file write.

---
 rtl/lsu_wb.sv | 204 ++++++++++++++++++++
 tb/tb_lsu_wb.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_wb.sv
// RV32I load/store unit: one op at a time, bus req held until gnt; load writeback 3 cycles after accept, store done 2 cycles after accept (no stalls).
// in_ready only in IDLE; TIMEOUT bounds gnt/rvalid waits. Define LSU_MISALIGN_TRAP_EN to reject misaligned ops instead of force-aligning them.
module lsu_wb #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [4:0]        in_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t              state_q;
  logic [15:0]         cnt_q;
  logic                store_q;
  logic [2:0]          f3_q;
  logic [1:0]          off_q;
  logic [4:0]          rd_q;
  logic                req_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic                wb_we_q;
  logic [4:0]          wb_rd_q;
  logic [31:0]         wb_data_q;
  logic                done_q;
  logic                err_q;

  logic                legal;
  logic                reject;
  logic [1:0]          off_d;
  logic [31:0]         wdata_d;
  logic [3:0]          wstrb_d;
  logic [31:0]         rshift;
  logic [31:0]         wb_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                misal;
`endif

  // Decode and lane-place the incoming op; only consumed on an accept.
  always_comb begin
    case (in_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !in_store;
      default:                legal = 1'b0;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    misal  = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
             ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
    reject = !legal || misal;
    off_d  = in_addr[1:0];
`else
    reject = !legal;
    case (in_funct3[1:0])
      2'b01:   off_d = {in_addr[1], 1'b0};
      2'b10:   off_d = 2'b00;
      default: off_d = in_addr[1:0];
    endcase
`endif
    wdata_d = in_wdata;
    wstrb_d = 4'b1111;
    case (in_funct3[1:0])
      2'b00: begin
        wdata_d = {4{in_wdata[7:0]}};
        wstrb_d = 4'b0001 << off_d;
      end
      2'b01: begin
        wdata_d = {2{in_wdata[15:0]}};
        wstrb_d = 4'b0011 << off_d;
      end
      default: ;
    endcase
    if (!in_store) wstrb_d = 4'b0000;
  end

  always_comb begin
    rshift = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  wb_data_d = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  wb_data_d = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  wb_data_d = {24'h0, rshift[7:0]};
      3'b101:  wb_data_d = {16'h0, rshift[15:0]};
      default: wb_data_d = rshift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      store_q   <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      rd_q      <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wb_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (reject) begin
              err_q <= 1'b1;
            end else begin
              store_q <= in_store;
              f3_q    <= in_funct3;
              off_q   <= off_d;
              rd_q    <= in_rd;
              req_q   <= 1'b1;
              we_q    <= in_store;
              addr_q  <= {in_addr[ADDR_W-1:2], 2'b00};
              wdata_q <= wdata_d;
              wstrb_q <= wstrb_d;
              cnt_q   <= '0;
              state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // A grant in the last permitted cycle still wins over the timeout.
          if (mem_gnt) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            cnt_q <= '0;
            if (store_q) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_WAIT;
            end
          end else if (cnt_q == CNT_LAST) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            wb_data_q <= wb_data_d;
            wb_rd_q   <= rd_q;
            wb_we_q   <= (rd_q != 5'd0);
            done_q    <= 1'b1;
            state_q   <= S_WB;
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lsu_wb.sv
// Bench for lsu_wb: directed vector table, random ops against a rule-level model, reset-mid-op sequences.
module tb_lsu_wb;

  localparam int TO    = 8;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_we, done, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int nvec = 0;
  int nmis = 0;

  lsu_wb #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_store(in_store), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Inputs first, then the expected outcome. exp_cyc is the cycle (1 = first
  // cycle after the accept edge) in which done or err shows.
  typedef struct {
    bit        store;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [4:0]  rd;
    int        gdly;
    int        rdly;
    bit [31:0] rdata;
    bit        exp_err;
    int        exp_cyc;
    int        exp_reqc;
    bit        exp_wb;
    bit [31:0] exp_wbd;
    bit [31:0] exp_addr;
    bit [3:0]  exp_wstrb;
    bit [31:0] exp_wdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t model(input vec_t vi);
    vec_t v;
    int size, off;
    bit legal;
    longint unsigned mask;
    logic [31:0] val, mult;
    v = vi;
    legal = vi.store ? (vi.f3 <= 3'd2) : (vi.f3 != 3'd3 && vi.f3 <= 3'd5);
    size  = 1 << vi.f3[1:0];
    off   = int'(vi.addr % 4);
    mask  = (64'd1 << (8 * size)) - 1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (off % size != 0) legal = 1'b0;
`else
    off = off - (off % size);
`endif
    v.exp_addr = vi.addr & ~32'h3;
    v.exp_err = 1'b0; v.exp_wb = 1'b0; v.exp_wbd = 0; v.exp_wstrb = 0; v.exp_wdata = 0;
    if (!legal) begin
      v.exp_err = 1'b1; v.exp_cyc = 1; v.exp_reqc = 0;
    end else begin
      v.exp_reqc = (vi.gdly >= TO) ? TO : vi.gdly + 1;
      if (vi.store) begin
        mult = (size == 1) ? 32'h01010101 : (size == 2) ? 32'h00010001 : 32'h1;
        v.exp_wstrb = 4'(((1 << size) - 1) << off);
        v.exp_wdata = 32'(vi.wdata & mask) * mult;
      end
      if (vi.gdly >= TO) begin
        v.exp_err = 1'b1; v.exp_cyc = TO + 1;
      end else if (vi.store) begin
        v.exp_cyc = vi.gdly + 2;
      end else if (vi.rdly >= TO) begin
        v.exp_err = 1'b1; v.exp_cyc = vi.gdly + 2 + TO;
      end else begin
        v.exp_cyc = vi.gdly + 3 + vi.rdly;
        v.exp_wb  = (vi.rd != 0);
        val = (vi.rdata >> (8 * off)) & 32'(mask);
        if (!vi.f3[2] && size < 4 && val[8*size-1]) val = val | ~32'(mask);
        v.exp_wbd = val;
      end
    end
    return v;
  endfunction

  task automatic run_op(input vec_t v);
    int reqc, g_at, first_evt, n_done, n_err, n_wb;
    logic [31:0] wbd;
    logic [4:0]  wbr;
    reqc = 0; g_at = -1; first_evt = 0; n_done = 0; n_err = 0; n_wb = 0; wbd = 0; wbr = 0;
    in_valid = 1'b1; in_store = v.store; in_funct3 = v.f3; in_addr = v.addr;
    in_wdata = v.wdata; in_rd = v.rd;
    @(posedge clk); #1;
    in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_rd = 5'($urandom);
    for (int c = 1; c <= v.exp_cyc + 2; c++) begin
      if (mem_req) begin
        reqc++;
        check("mem_addr", mem_addr, v.exp_addr);
        check("mem_we", 32'(mem_we), 32'(v.store));
        check("mem_wstrb", 32'(mem_wstrb), 32'(v.exp_wstrb));
        if (v.store) check("mem_wdata", mem_wdata, v.exp_wdata);
      end
      if ((done || err) && first_evt == 0) begin
        first_evt = c;
        check("retire_is_err", 32'(err), 32'(v.exp_err));
      end
      n_done += int'(done);
      n_err  += int'(err);
      if (wb_we) begin n_wb++; wbd = wb_data; wbr = wb_rd; end
      if (c == v.exp_cyc + 1) check("in_ready_after", 32'(in_ready), 32'd1);
      mem_gnt = mem_req && (reqc - 1 == v.gdly);
      if (mem_gnt) g_at = c;
      // Before the grant, stray rvalid with junk data must be ignored.
      if (g_at >= 0) mem_rvalid = (c == g_at + 1 + v.rdly);
      else           mem_rvalid = ($urandom_range(0, 3) == 0);
      mem_rdata = (mem_rvalid && g_at >= 0) ? v.rdata : $urandom;
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("retire_cycle", first_evt, v.exp_cyc);
    check("req_cycles", reqc, v.exp_reqc);
    check("done_pulses", n_done, v.exp_err ? 0 : 1);
    check("err_pulses", n_err, v.exp_err ? 1 : 0);
    check("wb_pulses", n_wb, 32'(v.exp_wb));
    if (v.exp_wb) begin
      check("wb_rd", 32'(wbr), 32'(v.rd));
      check("wb_data", wbd, v.exp_wbd);
    end
  endtask

  // Reset during REQ (at=1) or WAIT (at=2): the op must vanish without retiring.
  task automatic rst_mid(input int at);
    int pulses;
    pulses = 0;
    in_valid = 1'b1; in_store = 1'b0; in_funct3 = 3'b010; in_addr = 32'h40; in_rd = 5'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c < at; c++) begin
      mem_gnt = 1'b1;
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_req", 32'(mem_req), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 12; c++) begin
      if (done || err || wb_we || mem_req) pulses++;
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom;
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("rst_mid_quiet", pulses, 0);
  endtask

  vec_t tbl[17];
  vec_t rv;

  initial begin
    //        st f3    addr          wdata         rd  g   r      rdata          err cyc rq wb wbd            addr        strb   wdata
    tbl[0]  = '{0, 3'd2, 32'h100, 32'h0,        5'd5, 0, 0,     32'hDEADBEEF, 0, 3,  1, 1, 32'hDEADBEEF, 32'h100, 4'h0, 32'h0};
    tbl[1]  = '{0, 3'd0, 32'h103, 32'h0,        5'd1, 0, 0,     32'h80112233, 0, 3,  1, 1, 32'hFFFFFF80, 32'h100, 4'h0, 32'h0};
    tbl[2]  = '{0, 3'd4, 32'h103, 32'h0,        5'd2, 0, 0,     32'h80112233, 0, 3,  1, 1, 32'h00000080, 32'h100, 4'h0, 32'h0};
    tbl[3]  = '{1, 3'd1, 32'h202, 32'h0000ABCD, 5'd0, 4, 0,     32'h0,        0, 6,  5, 0, 32'h0,        32'h200, 4'hC, 32'hABCDABCD};
    tbl[4]  = '{0, 3'd2, 32'h104, 32'h0,        5'd0, 0, 0,     32'h12345678, 0, 3,  1, 0, 32'h0,        32'h104, 4'h0, 32'h0};
    tbl[5]  = '{0, 3'd2, 32'h108, 32'h0,        5'd3, 0, NEVER, 32'h0,        1, 10, 1, 0, 32'h0,        32'h108, 4'h0, 32'h0};
    tbl[6]  = '{0, 3'd1, 32'h102, 32'h0,        5'd4, 1, 2,     32'h80011234, 0, 6,  2, 1, 32'hFFFF8001, 32'h100, 4'h0, 32'h0};
    tbl[7]  = '{0, 3'd5, 32'h102, 32'h0,        5'd4, 0, 0,     32'h80011234, 0, 3,  1, 1, 32'h00008001, 32'h100, 4'h0, 32'h0};
    tbl[8]  = '{1, 3'd0, 32'h101, 32'h123456A5, 5'd0, 0, 0,     32'h0,        0, 2,  1, 0, 32'h0,        32'h100, 4'h2, 32'hA5A5A5A5};
    tbl[9]  = '{1, 3'd2, 32'h300, 32'h01020304, 5'd0, 2, 0,     32'h0,        0, 4,  3, 0, 32'h0,        32'h300, 4'hF, 32'h01020304};
    tbl[10] = '{1, 3'd2, 32'h304, 32'h55AA55AA, 5'd0, NEVER, 0, 32'h0,        1, 9,  8, 0, 32'h0,        32'h304, 4'hF, 32'h55AA55AA};
    tbl[11] = '{0, 3'd2, 32'h10C, 32'h0,        5'd9, 7, 7,     32'h0BADF00D, 0, 17, 8, 1, 32'h0BADF00D, 32'h10C, 4'h0, 32'h0};
    tbl[12] = '{0, 3'd3, 32'h110, 32'h0,        5'd9, 0, 0,     32'h0,        1, 1,  0, 0, 32'h0,        32'h110, 4'h0, 32'h0};
    tbl[13] = '{1, 3'd4, 32'h114, 32'h0,        5'd0, 0, 0,     32'h0,        1, 1,  0, 0, 32'h0,        32'h114, 4'h0, 32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[14] = '{0, 3'd2, 32'h101, 32'h0,        5'd7, 0, 0,     32'hCAFEF00D, 1, 1,  0, 0, 32'h0,        32'h100, 4'h0, 32'h0};
    tbl[15] = '{0, 3'd1, 32'h103, 32'h0,        5'd8, 0, 0,     32'hBEEF0001, 1, 1,  0, 0, 32'h0,        32'h100, 4'h0, 32'h0};
    tbl[16] = '{1, 3'd2, 32'h302, 32'h11223344, 5'd0, 0, 0,     32'h0,        1, 1,  0, 0, 32'h0,        32'h300, 4'hF, 32'h11223344};
`else
    tbl[14] = '{0, 3'd2, 32'h101, 32'h0,        5'd7, 0, 0,     32'hCAFEF00D, 0, 3,  1, 1, 32'hCAFEF00D, 32'h100, 4'h0, 32'h0};
    tbl[15] = '{0, 3'd1, 32'h103, 32'h0,        5'd8, 0, 0,     32'hBEEF0001, 0, 3,  1, 1, 32'hFFFFBEEF, 32'h100, 4'h0, 32'h0};
    tbl[16] = '{1, 3'd2, 32'h302, 32'h11223344, 5'd0, 0, 0,     32'h0,        0, 2,  1, 0, 32'h0,        32'h300, 4'hF, 32'h11223344};
`endif

    rst = 1'b1; in_valid = 1'b0; in_store = 1'b0; in_funct3 = 3'b0; in_addr = 32'h0;
    in_wdata = 32'h0; in_rd = 5'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);

    for (int i = 0; i < 17; i++) run_op(tbl[i]);

    rst_mid(1);
    rst_mid(2);
    run_op(tbl[0]);

    for (int i = 0; i < 60; i++) begin
      int k, x, y;
      rv.store = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        rv.f3 = 3'($urandom_range(0, 7));
      end else begin
        k = rv.store ? $urandom_range(0, 2) : $urandom_range(0, 4);
        rv.f3 = 3'((k < 3) ? k : k + 1);
      end
      rv.addr  = $urandom;
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.rd    = 5'($urandom);
      x = $urandom_range(0, 9);
      y = $urandom_range(0, 9);
      rv.gdly = (x < 4) ? x : (x < 7) ? 0 : (x == 9) ? NEVER : x - 1;
      rv.rdly = (y < 4) ? y : (y < 7) ? 0 : (y == 9) ? NEVER : y - 1;
      run_op(model(rv));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at t=%0t, wanted completion", $time);
    $fatal(1);
  end

endmodule
